// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous-read memory between the CPU port and the DMA/debug
//   loader port. It issues at most one access per cycle and steers the read
//   data back to whichever requester issued the read.
//
//   Arbitration order:
//     1. a locked DMA burst that is still requesting
//     2. a DMA request that has waited STARVE_LIMIT CPU grants
//     3. the CPU
//     4. the DMA
//
// Ports
//   clock, reset_n             rising-edge clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata      CPU request, held by the CPU until cpu_gnt
//   cpu_gnt                    CPU access issued this cycle (combinational)
//   cpu_rvalid/cpu_rdata       CPU read return, one cycle after the grant
//   dma_req/we/addr/wdata      DMA request, held by the DMA until dma_gnt
//   dma_lock                   taken with a granted DMA access; keeps DMA
//                              ownership for its next access (burst)
//   dma_gnt                    DMA access issued this cycle (combinational)
//   dma_rvalid/dma_rdata       DMA read return, one cycle after the grant
//   mem_we/addr/wdata          memory command; all zero when no access is issued
//   mem_rdata                  memory read data, valid one cycle after the address
module mem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic             lock_owned_reg, lock_owned_next;
  logic             cpu_win, dma_win;

  // Read return pipeline, one lane per requester: index 0 = CPU, 1 = DMA.
  logic              rd_gnt       [2];
  logic              rvalid_reg   [2];
  logic [DATA_W-1:0] rdata_hold_reg [2];
  logic [DATA_W-1:0] rdata_mux    [2];

  // Grant decision. The grants are qualified with reset_n so that they are
  // forced low while reset is asserted, with no wait for a clock edge.
  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (reset_n) begin
      if (dma_req && (lock_owned_reg || starve_cnt_reg == LIMIT_C)) begin
        dma_win = 1'b1;
      end else if (cpu_req) begin
        cpu_win = 1'b1;
      end else if (dma_req) begin
        dma_win = 1'b1;
      end
    end
  end

  assign cpu_gnt = cpu_win;
  assign dma_gnt = dma_win;

  // Memory command mux; idle cycles present an all-zero command.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_win) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_win) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  // starve_cnt counts CPU grants taken while DMA waits. It resets once DMA
  // is served or stops asking.
  // lock_owned follows dma_lock on each DMA grant and is released as soon as
  // DMA stops requesting.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    lock_owned_next = lock_owned_reg;
    if (dma_win || !dma_req) begin
      starve_cnt_next = '0;
    end else if (cpu_win && starve_cnt_reg != LIMIT_C) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
    if (dma_win) begin
      lock_owned_next = dma_lock;
    end else if (!dma_req) begin
      lock_owned_next = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_reg <= '0;
      lock_owned_reg <= 1'b0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      lock_owned_reg <= lock_owned_next;
    end
  end

  always_comb begin
    rd_gnt[0] = cpu_win & ~cpu_we;
    rd_gnt[1] = dma_win & ~dma_we;
  end

  // Per-lane read return. The memory's own output register supplies the
  // returned word, so the lane passes mem_rdata straight through in its
  // rvalid cycle and captures it so rdata holds between returns.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          rvalid_reg[gi]     <= 1'b0;
          rdata_hold_reg[gi] <= '0;
        end else begin
          rvalid_reg[gi] <= rd_gnt[gi];
          if (rvalid_reg[gi]) begin
            rdata_hold_reg[gi] <= mem_rdata;
          end
        end
      end

      assign rdata_mux[gi] = rvalid_reg[gi] ? mem_rdata : rdata_hold_reg[gi];
    end
  endgenerate

  assign cpu_rvalid = rvalid_reg[0];
  assign dma_rvalid = rvalid_reg[1];
  assign cpu_rdata  = rdata_mux[0];
  assign dma_rdata  = rdata_mux[1];

endmodule
